// File: rtl/data_sync_mc.sv
// Multi-channel enable-qualified bus synchronizer.
// Each channel's enable crosses into CLK through a flop chain. A detected
// event captures that channel's bus, pulses enable_pulse and fills a
// one-entry holding buffer. Buffered words leave through a round-robin
// valid/ready port that keeps its choice stable while stalled. Dropped
// events set sticky overrun flags.
module data_sync_mc #(
  parameter int NUM_STAGES  = 2,
  parameter int BUS_WIDTH   = 8,
  parameter int NUM_CH      = 4,
  parameter int TOGGLE_MODE = 0,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
  input  logic [NUM_CH-1:0]           bus_enable,
  output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
  output logic [NUM_CH-1:0]           enable_pulse,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BUS_WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]             out_ch,
  output logic [NUM_CH-1:0]           overrun,
  input  logic                        clear_overrun
);

  // Stage NUM_STAGES-1 is the synchronized enable 's'.
  logic [NUM_STAGES-1:0][NUM_CH-1:0] sync_q;
  logic [NUM_CH-1:0]                 prev_q;
  logic [NUM_CH-1:0]                 sync_s;
  logic [NUM_CH-1:0]                 event_s;

  logic [NUM_CH-1:0][BUS_WIDTH-1:0]  hold_q;
  logic [NUM_CH-1:0]                 valid_q;

  logic [CH_W-1:0]                   rr_ptr_q;
  logic                              lock_q;
  logic [CH_W-1:0]                   lock_ch_q;

  logic [CH_W-1:0]                   pick_ch;
  logic [CH_W-1:0]                   sel_ch;
  logic [CH_W-1:0]                   next_ptr;
  logic                              accept;
  logic [NUM_CH-1:0]                 accept_vec;
  logic [NUM_CH-1:0]                 drop_s;

  assign sync_s  = sync_q[NUM_STAGES-1];
  assign event_s = (TOGGLE_MODE != 0) ? (sync_s ^ prev_q) : (sync_s & ~prev_q);

  // Enable synchronizer chain plus the pulse flop that remembers last 's'.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, giving a true shift chain.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[NUM_STAGES-2:0], bus_enable};
      prev_q <= sync_s;
    end
  end

  // Round-robin search: first valid channel at or above rr_ptr, wrapping.
  // NOTE: combinational outputs get a default before any conditional
  // assignment so no path leaves them unassigned, which would infer a latch.
  always_comb begin
    logic [CH_W:0] idx;
    pick_ch = '0;
    idx     = '0;
    // Walk offsets from the far end so the nearest valid channel wins last.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr_q} + (CH_W+1)'(k);
      if (idx >= (CH_W+1)'(NUM_CH)) idx = idx - (CH_W+1)'(NUM_CH);
      if (valid_q[idx[CH_W-1:0]]) pick_ch = idx[CH_W-1:0];
    end
  end

  // Output port: a stalled word stays locked to its channel until accepted.
  always_comb begin
    sel_ch     = lock_q ? lock_ch_q : pick_ch;
    out_valid  = |valid_q;
    out_ch     = out_valid ? sel_ch : '0;
    out_data   = out_valid ? hold_q[sel_ch] : '0;
    accept     = out_valid & out_ready;
    accept_vec = accept ? (NUM_CH'(1) << sel_ch) : '0;
    next_ptr   = (sel_ch == CH_W'(NUM_CH - 1)) ? '0 : sel_ch + 1'b1;
  end

  // An event on a full buffer that is not being drained this cycle is lost.
  assign drop_s = event_s & valid_q & ~accept_vec;

  // Capture, holding buffers and sticky overrun flags.
  // NOTE: the holding buffers are reset along with their valid bits so a
  // freshly reset block presents deterministic zeros everywhere.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_bus     <= '0;
      enable_pulse <= '0;
      hold_q       <= '0;
      valid_q      <= '0;
      overrun      <= '0;
    end else begin
      enable_pulse <= event_s;
      // A new overrun in the same cycle as clear_overrun stays set.
      overrun      <= (clear_overrun ? '0 : overrun) | drop_s;
      for (int i = 0; i < NUM_CH; i++) begin
        if (event_s[i]) begin
          sync_bus[i*BUS_WIDTH +: BUS_WIDTH] <= unsync_bus[i*BUS_WIDTH +: BUS_WIDTH];
        end
        if (event_s[i] && (!valid_q[i] || accept_vec[i])) begin
          hold_q[i]  <= unsync_bus[i*BUS_WIDTH +: BUS_WIDTH];
          valid_q[i] <= 1'b1;
        end else if (accept_vec[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  // Arbiter state: advance the pointer on acceptance, lock while stalled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else if (accept) begin
      rr_ptr_q  <= next_ptr;
      lock_q    <= 1'b0;
    end else if (out_valid) begin
      lock_q    <= 1'b1;
      lock_ch_q <= sel_ch;
    end
  end

endmodule

// File: tb/tb_data_sync_mc.sv
// Bench for data_sync_mc: a level-mode instance and a toggle-mode instance
// with NUM_STAGES=2, BUS_WIDTH=8, NUM_CH=4.
module tb_data_sync_mc;

  localparam int NS  = 2;
  localparam int BW  = 8;
  localparam int NCH = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NCH*BW-1:0] unsync_bus;
  logic [NCH-1:0]    bus_enable;
  logic [NCH*BW-1:0] sync_bus;
  logic [NCH-1:0]    enable_pulse;
  logic              out_valid;
  logic              out_ready;
  logic [BW-1:0]     out_data;
  logic [1:0]        out_ch;
  logic [NCH-1:0]    overrun;
  logic              clear_overrun;

  logic [NCH*BW-1:0] t_unsync_bus;
  logic [NCH-1:0]    t_bus_enable;
  logic [NCH*BW-1:0] t_sync_bus;
  logic [NCH-1:0]    t_enable_pulse;
  logic              t_out_valid;
  logic              t_out_ready;
  logic [BW-1:0]     t_out_data;
  logic [1:0]        t_out_ch;
  logic [NCH-1:0]    t_overrun;
  logic              t_clear_overrun;

  always #5 CLK = ~CLK;

  data_sync_mc #(.NUM_STAGES(NS), .BUS_WIDTH(BW), .NUM_CH(NCH), .TOGGLE_MODE(0)) dut (
    .CLK(CLK), .RST(RST), .unsync_bus(unsync_bus), .bus_enable(bus_enable),
    .sync_bus(sync_bus), .enable_pulse(enable_pulse), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .overrun(overrun), .clear_overrun(clear_overrun)
  );

  data_sync_mc #(.NUM_STAGES(NS), .BUS_WIDTH(BW), .NUM_CH(NCH), .TOGGLE_MODE(1)) dut_t (
    .CLK(CLK), .RST(RST), .unsync_bus(t_unsync_bus), .bus_enable(t_bus_enable),
    .sync_bus(t_sync_bus), .enable_pulse(t_enable_pulse), .out_valid(t_out_valid),
    .out_ready(t_out_ready), .out_data(t_out_data), .out_ch(t_out_ch),
    .overrun(t_overrun), .clear_overrun(t_clear_overrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string name, input logic v, input logic [1:0] c, input logic [7:0] d);
    check({name, "_valid"}, out_valid, v);
    check({name, "_ch"}, out_ch, c);
    check({name, "_data"}, out_data, d);
  endtask

  // Reference model of the level-mode instance. An event at edge k is a
  // rising edge of the sampled enable sequence delayed by NS edges.
  logic [NCH-1:0] hist [NS+1];
  logic [BW-1:0]  m_buf  [NCH];
  logic [BW-1:0]  m_sync [NCH];
  logic [NCH-1:0] m_full;
  logic [NCH-1:0] m_pulse;
  logic [NCH-1:0] m_ovr;
  int             m_ptr;
  int             m_held;

  task automatic model_reset();
    for (int k = 0; k <= NS; k++) hist[k] = '0;
    for (int c = 0; c < NCH; c++) begin
      m_buf[c]  = '0;
      m_sync[c] = '0;
    end
    m_full  = '0;
    m_pulse = '0;
    m_ovr   = '0;
    m_ptr   = 0;
    m_held  = -1;
  endtask

  // Channel currently presented, or -1 when nothing is buffered.
  function automatic int pres_ch();
    if (m_held >= 0) return m_held;
    for (int k = 0; k < NCH; k++) begin
      if (m_full[(m_ptr + k) % NCH]) return (m_ptr + k) % NCH;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic [NCH-1:0] ev;
    logic [NCH-1:0] drop;
    int             pc;
    bit             acc;
    bit             taken;
    if (RST) begin
      model_reset();
      return;
    end
    ev   = hist[NS-1] & ~hist[NS];
    pc   = pres_ch();
    acc  = (pc >= 0) && out_ready;
    drop = '0;
    for (int c = 0; c < NCH; c++) begin
      taken = acc && (pc == c);
      if (ev[c]) begin
        m_sync[c] = unsync_bus[c*BW +: BW];
        if (!m_full[c] || taken) begin
          m_buf[c]  = unsync_bus[c*BW +: BW];
          m_full[c] = 1'b1;
        end else begin
          drop[c] = 1'b1;
        end
      end else if (taken) begin
        m_full[c] = 1'b0;
      end
    end
    m_pulse = ev;
    m_ovr   = (clear_overrun ? '0 : m_ovr) | drop;
    if (acc) begin
      m_held = -1;
      m_ptr  = (pc + 1) % NCH;
    end else if (pc >= 0) begin
      m_held = pc;
    end
    for (int k = NS; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = bus_enable;
  endtask

  task automatic compare_model();
    int pc;
    pc = pres_ch();
    check("rnd_sync", sync_bus, {m_sync[3], m_sync[2], m_sync[1], m_sync[0]});
    check("rnd_pulse", enable_pulse, m_pulse);
    check("rnd_ovr", overrun, m_ovr);
    if (pc >= 0) check_out("rnd", 1'b1, 2'(pc), m_buf[pc]);
    else         check_out("rnd", 1'b0, 2'd0, 8'h00);
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [7:0] val);
    unsync_bus[ch*BW +: BW] = val;
  endtask

  task automatic fire(input logic [NCH-1:0] mask);
    bus_enable = mask;
    tick();
    bus_enable = '0;
  endtask

  typedef struct {
    logic       en;
    logic [7:0] data;
    logic       ready;
    logic       pulse;
    logic       valid;
    logic [1:0] ch;
    logic [7:0] odata;
    logic [7:0] sync;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Single-pulse latency on channel 0: one row per clock edge.
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00};
    vecs[2] = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 2'd0, 8'hA5, 8'hA5};
    vecs[3] = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 8'hA5};
    vecs[4] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'hA5};

    RST = 1'b1;
    unsync_bus = '0;
    bus_enable = '0;
    out_ready = 1'b0;
    clear_overrun = 1'b0;
    t_unsync_bus = '0;
    t_bus_enable = '0;
    t_out_ready = 1'b0;
    t_clear_overrun = 1'b0;
    model_reset();
    tick();
    tick();
    check("rst_sync", sync_bus, 32'h0);
    check("rst_pulse", enable_pulse, 4'h0);
    check("rst_ovr", overrun, 4'h0);
    check_out("rst", 1'b0, 2'd0, 8'h00);
    check("rst_t_valid", t_out_valid, 1'b0);
    RST = 1'b0;

    for (int i = 0; i < 5; i++) begin
      bus_enable[0]   = vecs[i].en;
      unsync_bus[7:0] = vecs[i].data;
      out_ready       = vecs[i].ready;
      tick();
      check("tbl_pulse", enable_pulse[0], vecs[i].pulse);
      check("tbl_sync", sync_bus[7:0], vecs[i].sync);
      check_out("tbl", vecs[i].valid, vecs[i].ch, vecs[i].odata);
    end

    // Round robin: channels 1..3 together, then 0 and 1 after the wrap.
    out_ready = 1'b1;
    set_data(1, 8'h3C); set_data(2, 8'h55); set_data(3, 8'h0F);
    fire(4'b1110); tick(); tick();
    check_out("rr_a", 1'b1, 2'd1, 8'h3C);
    tick(); check_out("rr_b", 1'b1, 2'd2, 8'h55);
    tick(); check_out("rr_c", 1'b1, 2'd3, 8'h0F);
    tick(); check_out("rr_d", 1'b0, 2'd0, 8'h00);
    set_data(0, 8'h11); set_data(1, 8'h22);
    fire(4'b0011); tick(); tick();
    check_out("rr_e", 1'b1, 2'd0, 8'h11);
    tick(); check_out("rr_f", 1'b1, 2'd1, 8'h22);
    tick(); check_out("rr_g", 1'b0, 2'd0, 8'h00);
    // Move the pointer back to channel 0.
    set_data(3, 8'h3E);
    fire(4'b1000); tick(); tick();
    check_out("rr_h", 1'b1, 2'd3, 8'h3E);
    tick(); check_out("rr_i", 1'b0, 2'd0, 8'h00);

    // Backpressure: channel 2 stays presented while channel 0 arrives.
    out_ready = 1'b0;
    set_data(2, 8'hAA);
    fire(4'b0100); tick(); tick();
    check_out("bp_a", 1'b1, 2'd2, 8'hAA);
    set_data(0, 8'hBB);
    fire(4'b0001); tick(); tick();
    check_out("bp_b", 1'b1, 2'd2, 8'hAA);
    tick(); check_out("bp_c", 1'b1, 2'd2, 8'hAA);
    out_ready = 1'b1;
    tick(); check_out("bp_d", 1'b1, 2'd0, 8'hBB);
    tick(); check_out("bp_e", 1'b0, 2'd0, 8'h00);
    out_ready = 1'b0;

    // Overrun on channel 1, clear, then refill with same-cycle acceptance.
    set_data(1, 8'h77);
    fire(4'b0010); tick(); tick();
    check_out("ov_a", 1'b1, 2'd1, 8'h77);
    tick();
    set_data(1, 8'h99);
    fire(4'b0010); tick(); tick();
    check("ov_flag", overrun, 4'b0010);
    check("ov_pulse", enable_pulse, 4'b0010);
    check("ov_sync", sync_bus[15:8], 8'h99);
    check_out("ov_b", 1'b1, 2'd1, 8'h77);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    check("ov_clear", overrun, 4'b0000);
    check_out("ov_c", 1'b1, 2'd1, 8'h77);
    tick();
    fire(4'b0010); tick();
    out_ready = 1'b1;
    tick();
    check("ov_refill_flag", overrun, 4'b0000);
    check_out("ov_d", 1'b1, 2'd1, 8'h99);
    tick(); check_out("ov_e", 1'b0, 2'd0, 8'h00);
    out_ready = 1'b0;

    // Toggle-mode instance: both enable transitions capture.
    t_unsync_bus[7:0] = 8'h12;
    t_bus_enable[0] = 1'b1;
    tick(); tick(); tick();
    check("tg_pulse_a", t_enable_pulse, 4'b0001);
    check("tg_data_a", t_out_data, 8'h12);
    check("tg_valid_a", t_out_valid, 1'b1);
    tick();
    check("tg_pulse_b", t_enable_pulse, 4'b0000);
    t_out_ready = 1'b1;
    tick();
    t_out_ready = 1'b0;
    check("tg_valid_b", t_out_valid, 1'b0);
    t_unsync_bus[7:0] = 8'h34;
    t_bus_enable[0] = 1'b0;
    tick(); tick(); tick();
    check("tg_pulse_c", t_enable_pulse, 4'b0001);
    check("tg_sync_c", t_sync_bus[7:0], 8'h34);
    check("tg_data_c", t_out_data, 8'h34);
    check("tg_ovr_c", t_overrun, 4'b0000);
    tick();
    check("tg_pulse_d", t_enable_pulse, 4'b0000);

    // Reset one cycle after channel 3's enable rises, enable held high.
    set_data(3, 8'h5A);
    bus_enable[3] = 1'b1;
    tick();
    RST = 1'b1;
    tick();
    check("mr_sync", sync_bus, 32'h0);
    check("mr_pulse", enable_pulse, 4'h0);
    check_out("mr_a", 1'b0, 2'd0, 8'h00);
    tick();
    check("mr_ovr", overrun, 4'h0);
    check_out("mr_b", 1'b0, 2'd0, 8'h00);
    RST = 1'b0;
    tick(); tick();
    check("mr_early", enable_pulse, 4'h0);
    tick();
    check("mr_pulse_c", enable_pulse, 4'b1000);
    check("mr_sync_c", sync_bus[31:24], 8'h5A);
    check_out("mr_c", 1'b1, 2'd3, 8'h5A);
    tick();
    check("mr_once", enable_pulse, 4'h0);
    bus_enable[3] = 1'b0;

    // Randomized traffic against the reference model.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(3) == 0) bus_enable[c] = ~bus_enable[c];
      end
      unsync_bus    = $urandom;
      out_ready     = 1'($urandom_range(1));
      clear_overrun = ($urandom_range(15) == 0);
      tick();
      compare_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
